// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: digit count, segment bit positions,
// blank pattern and the active-low hex-to-segment lookup.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Bit positions inside the {dp,g,f,e,d,c,b,a} segment byte.
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // All segments off (active-low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nib_i);

endmodule

// File: rtl/spi_word_display.sv
// Latches the SPI-received word on each rising edge of the frame strobe and
// scans it (or the frame counter when sel=1) across a 4-digit multiplexed
// seven-segment display. The decimal point of the rightmost digit flags
// freshly captured data for NEWTICKS scan ticks.
//
// Strobe protocol: load is a level from the SPI core; only its rising edge
// (load & ~load_q) counts as a frame, so a strobe held high for many cycles
// is one frame. rx_dat must be valid in the cycle load rises.
//
// Scan ordering: the digit index register holds the digit to be driven at
// the next scan tick, so the first tick after reset lights digit 0.
// CLKFREQ/SCANFREQ must be at least 2 and NEWTICKS at least 1.
module spi_word_display
    import seg7_pkg::*;
#(
    parameter int CLKFREQ  = 27000000,
    parameter int SCANFREQ = 1000,
    parameter int WIDTH    = 13,
    parameter int NEWTICKS = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] rx_dat,
    input  logic             sel,
    input  logic             hold,
    output logic [3:0]       digits,
    output logic [7:0]       segments,
    output logic [15:0]      frame_cnt
);

    localparam int DIV  = CLKFREQ / SCANFREQ;
    localparam int DIVW = $clog2(DIV);
    localparam int NEWW = $clog2(NEWTICKS + 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
    localparam logic [NEWW-1:0] NEW_LOAD = NEWW'(NEWTICKS);

    logic             load_q;
    logic [15:0]      word_q, word_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [DIVW-1:0]  div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [NEWW-1:0]  new_q, new_d, new_cap;
    logic [3:0]       digits_q, digits_d;
    logic [7:0]       seg_q, seg_d;

    logic             cap;
    logic             take;
    logic             tick;
    logic [15:0]      disp;
    logic [3:0]       nib;
    logic [6:0]       seg7;

    hex_to_seg7 u_hex_to_seg7 (
        .nib_i (nib),
        .seg_o (seg7)
    );

    // Next-state logic: capture is resolved first so a coincident scan tick
    // already sees the new word / count and the reloaded new-data counter.
    always_comb begin
        cap         = load & ~load_q;
        take        = cap & ~hold;
        tick        = (div_q == DIV_LAST);
        div_d       = tick ? '0 : div_q + 1'b1;
        frame_cnt_d = cap ? frame_cnt_q + 16'd1 : frame_cnt_q;
        word_d      = word_q;
        new_cap     = new_q;
        if (take) begin
            word_d  = 16'(rx_dat);
            new_cap = NEW_LOAD;
        end
        new_d = new_cap;
        if (tick && !take && (new_q != '0)) begin
            new_d = new_q - 1'b1;
        end
        disp     = sel ? frame_cnt_d : word_d;
        nib      = disp[{idx_q, 2'b00} +: 4];
        idx_d    = idx_q;
        digits_d = digits_q;
        seg_d    = seg_q;
        if (tick) begin
            idx_d    = idx_q + 2'd1;
            digits_d = ~(4'b0001 << idx_q);
            seg_d    = {~((idx_q == 2'd0) && (new_cap != '0)), seg7};
        end
    end

    // State registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q      <= 1'b0;
            word_q      <= '0;
            frame_cnt_q <= '0;
            div_q       <= '0;
            idx_q       <= '0;
            new_q       <= '0;
            digits_q    <= 4'b1111;
            seg_q       <= SEG_BLANK;
        end else begin
            load_q      <= load;
            word_q      <= word_d;
            frame_cnt_q <= frame_cnt_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            new_q       <= new_d;
            digits_q    <= digits_d;
            seg_q       <= seg_d;
        end
    end

    assign digits    = digits_q;
    assign segments  = seg_q;
    assign frame_cnt = frame_cnt_q;

endmodule
